// File: rtl/axis_testpattern_burst_ctrl.sv
// Packetising sequencer between a free-running AXIS test-pattern source and its consumer.
// After a start pulse it forwards num_packets packets of PACKET_LEN beats with tlast on the
// final beat. It inserts GAP_CYCLES idle cycles between packets and then returns to idle
// with a one-cycle done pulse. num_packets == 0 runs until abort. Abort always lets the
// current packet finish.
module axis_testpattern_burst_ctrl #(
  parameter int unsigned TDATA_WIDTH = 32,
  parameter int unsigned PACKET_LEN  = 16,
  parameter int unsigned GAP_CYCLES  = 4,
  parameter int unsigned NUM_WIDTH   = 16
) (
  input  logic                   m_axis_aclk,
  input  logic                   m_axis_aresetn,
  input  logic                   start,
  input  logic                   abort,
  input  logic [NUM_WIDTH-1:0]   num_packets,
  output logic                   gen_enable,
  input  logic [TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  output logic [TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  output logic                   busy,
  output logic                   done,
  output logic [NUM_WIDTH-1:0]   pkt_count
);

  localparam int unsigned BeatW = $clog2(PACKET_LEN + 1);
  localparam int unsigned GapW  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [BeatW-1:0] BeatLast = BeatW'(PACKET_LEN - 1);
  // Unused when GAP_CYCLES == 0; the gap state is never entered in that case.
  localparam logic [GapW-1:0]  GapLast  = GapW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  typedef enum logic [1:0] {StIdle, StStream, StGap} state_e;

  state_e               state_q, state_d;
  logic [BeatW-1:0]     beat_cnt_q, beat_cnt_d;
  logic [GapW-1:0]      gap_cnt_q, gap_cnt_d;
  logic [NUM_WIDTH-1:0] num_q, num_d;
  logic [NUM_WIDTH-1:0] pkt_count_q, pkt_count_d, pkt_count_inc;
  logic                 abort_q, abort_d;
  logic                 done_q, done_d;
  logic                 in_stream, xfer, abort_any;

  // Zero-latency pass-through datapath, gated by the stream state.
  assign in_stream     = (state_q == StStream);
  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tvalid = in_stream & s_axis_tvalid;
  assign s_axis_tready = in_stream & m_axis_tready;
  assign m_axis_tlast  = in_stream & (beat_cnt_q == BeatLast);
  assign xfer          = m_axis_tvalid & m_axis_tready;

  assign gen_enable    = (state_q != StIdle);
  assign busy          = (state_q != StIdle);
  assign done          = done_q;
  assign pkt_count     = pkt_count_q;

  // A same-cycle abort counts exactly like an already latched one.
  assign abort_any     = abort_q | abort;
  assign pkt_count_inc = pkt_count_q + NUM_WIDTH'(1);

  // Next-state logic: sequencing of packets, gaps and termination.
  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    num_d       = num_q;
    pkt_count_d = pkt_count_q;
    abort_d     = abort_q;
    done_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d     = StStream;
          num_d       = num_packets;
          pkt_count_d = '0;
          beat_cnt_d  = '0;
          gap_cnt_d   = '0;
          abort_d     = 1'b0;
        end
      end
      StStream: begin
        abort_d = abort_any;
        if (xfer) begin
          if (m_axis_tlast) begin
            beat_cnt_d  = '0;
            pkt_count_d = pkt_count_inc;
            if (abort_any || ((num_q != '0) && (pkt_count_inc == num_q))) begin
              state_d = StIdle;
              done_d  = 1'b1;
            end else if (GAP_CYCLES > 0) begin
              state_d   = StGap;
              gap_cnt_d = '0;
            end
          end else begin
            beat_cnt_d = beat_cnt_q + BeatW'(1);
          end
        end
      end
      StGap: begin
        abort_d = abort_any;
        if (abort_any) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else if (gap_cnt_q == GapLast) begin
          state_d = StStream;
        end else begin
          gap_cnt_d = gap_cnt_q + GapW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge m_axis_aclk) begin
    if (!m_axis_aresetn) begin
      state_q     <= StIdle;
      beat_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      num_q       <= '0;
      pkt_count_q <= '0;
      abort_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      num_q       <= num_d;
      pkt_count_q <= pkt_count_d;
      abort_q     <= abort_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_axis_testpattern_burst_ctrl.sv
// Bench for axis_testpattern_burst_ctrl: two instances (GAP_CYCLES=2 and 0) share control
// inputs and are checked every cycle against a packet-level behavioural model, plus literal
// per-run totals for directed scenarios.
module tb_axis_testpattern_burst_ctrl;

  localparam int PL = 4;
  localparam int NW = 8;
  localparam int NMOD = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn, start, abort, m_tready;
  logic [NW-1:0] num;
  logic [31:0]   s_tdata [2];
  logic          s_tvalid [2];
  logic          s_tready [2];
  logic [31:0]   m_tdata [2];
  logic          m_tvalid [2];
  logic          m_tlast [2];
  logic          gen_en [2];
  logic          busy [2];
  logic          done [2];
  logic [NW-1:0] pkt_count [2];

  axis_testpattern_burst_ctrl #(
    .TDATA_WIDTH(32), .PACKET_LEN(PL), .GAP_CYCLES(2), .NUM_WIDTH(NW)
  ) u_dut_gap (
    .m_axis_aclk(clk), .m_axis_aresetn(rstn), .start(start), .abort(abort),
    .num_packets(num), .gen_enable(gen_en[0]), .s_axis_tdata(s_tdata[0]),
    .s_axis_tvalid(s_tvalid[0]), .s_axis_tready(s_tready[0]), .m_axis_tdata(m_tdata[0]),
    .m_axis_tvalid(m_tvalid[0]), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast[0]),
    .busy(busy[0]), .done(done[0]), .pkt_count(pkt_count[0])
  );

  axis_testpattern_burst_ctrl #(
    .TDATA_WIDTH(32), .PACKET_LEN(PL), .GAP_CYCLES(0), .NUM_WIDTH(NW)
  ) u_dut_nogap (
    .m_axis_aclk(clk), .m_axis_aresetn(rstn), .start(start), .abort(abort),
    .num_packets(num), .gen_enable(gen_en[1]), .s_axis_tdata(s_tdata[1]),
    .s_axis_tvalid(s_tvalid[1]), .s_axis_tready(s_tready[1]), .m_axis_tdata(m_tdata[1]),
    .m_axis_tvalid(m_tvalid[1]), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast[1]),
    .busy(busy[1]), .done(done[1]), .pkt_count(pkt_count[1])
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Packet-level model: run flag, remaining-gap phase, beat index within packet.
  int gap_len [2] = '{2, 0};
  bit m_run [2], m_ingap [2], m_abl [2], m_done [2];
  int m_gapi [2], m_beat [2], m_pkts [2], m_num [2];

  // Per-run observed totals (cleared when a start is accepted).
  int st_xfer [2], st_last [2], st_busy [2], st_pkt [2];

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_run[k] = 0; m_ingap[k] = 0; m_abl[k] = 0; m_done[k] = 0;
      m_gapi[k] = 0; m_beat[k] = 0; m_pkts[k] = 0; m_num[k] = 0;
      st_xfer[k] = 0; st_last[k] = 0; st_busy[k] = 0; st_pkt[k] = -1;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        bit strm, xf, lastb, ab;
        int np;
        strm  = m_run[k] && !m_ingap[k];
        xf    = strm && s_tvalid[k] && m_tready;
        lastb = strm && (m_beat[k] == PL - 1);
        chk($sformatf("ctrl%0d{gen,busy,done,rdy,vld,last}", k),
            {gen_en[k], busy[k], done[k], s_tready[k], m_tvalid[k], m_tlast[k]},
            {m_run[k], m_run[k], m_done[k], strm && m_tready, strm && s_tvalid[k], lastb});
        chk($sformatf("pkt_count%0d", k), pkt_count[k], m_pkts[k]);
        chk($sformatf("tdata%0d", k), m_tdata[k], s_tdata[k]);

        if (busy[k]) st_busy[k]++;
        if (m_tvalid[k] && m_tready) st_xfer[k]++;
        if (m_tvalid[k] && m_tready && m_tlast[k]) st_last[k]++;
        if (done[k]) st_pkt[k] = int'(pkt_count[k]);
        if (rstn && start && !busy[k]) begin
          st_xfer[k] = 0; st_last[k] = 0; st_busy[k] = 0; st_pkt[k] = -1;
        end

        m_done[k] = 0;
        if (!rstn) begin
          m_run[k] = 0; m_ingap[k] = 0; m_abl[k] = 0; m_gapi[k] = 0;
          m_beat[k] = 0; m_pkts[k] = 0;
        end else if (!m_run[k]) begin
          if (start) begin
            m_run[k] = 1; m_ingap[k] = 0; m_beat[k] = 0; m_pkts[k] = 0;
            m_num[k] = int'(num); m_abl[k] = 0;
          end
        end else begin
          ab = m_abl[k] || abort;
          m_abl[k] = ab;
          if (!m_ingap[k]) begin
            if (xf && lastb) begin
              m_beat[k] = 0;
              np = (m_pkts[k] + 1) % NMOD;
              m_pkts[k] = np;
              if (ab || (m_num[k] != 0 && np == m_num[k])) begin
                m_run[k] = 0; m_done[k] = 1;
              end else if (gap_len[k] > 0) begin
                m_ingap[k] = 1; m_gapi[k] = 0;
              end
            end else if (xf) begin
              m_beat[k] = m_beat[k] + 1;
            end
          end else begin
            if (ab) begin
              m_run[k] = 0; m_ingap[k] = 0; m_done[k] = 1;
            end else if (m_gapi[k] == gap_len[k] - 1) begin
              m_ingap[k] = 0;
            end else begin
              m_gapi[k] = m_gapi[k] + 1;
            end
          end
        end
      end
    end
  end

  // 0: ready always high, 1: toggling, 2: random. Source 0: always valid, 1: random valid.
  int ready_mode = 0;
  int src_mode = 0;

  // One clock cycle; sources obey AXIS (valid held until accepted, data advances on accept).
  task automatic step();
    bit hs [2];
    @(negedge clk);
    for (int k = 0; k < 2; k++) hs[k] = s_tvalid[k] && s_tready[k];
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      if (hs[k]) s_tdata[k] = s_tdata[k] + 32'd1;
      if (hs[k] || !s_tvalid[k])
        s_tvalid[k] = (src_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
    end
    case (ready_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = ~m_tready;
      default: m_tready = ($urandom_range(0, 2) != 0);
    endcase
  endtask

  task automatic pulse_start(input int n);
    num = NW'(n);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy[0] || busy[1]) && n < 2000) begin
      step();
      n++;
    end
    chk("wait_idle_timeout", busy[0] || busy[1], 0);
    step();
    step();
  endtask

  task automatic wait_xfer(input int k, input int cnt);
    int n = 0;
    while (st_xfer[k] != cnt && n < 500) begin
      step();
      n++;
    end
    chk("wait_xfer_timeout", st_xfer[k], cnt);
  endtask

  task automatic wait_last(input int k, input int cnt);
    int n = 0;
    while (st_last[k] != cnt && n < 500) begin
      step();
      n++;
    end
    chk("wait_last_timeout", st_last[k], cnt);
  endtask

  task automatic totals(input string t, input int k, input int xf, input int ls, input int pk,
                        input int bz);
    chk($sformatf("%s_beats%0d", t, k), st_xfer[k], xf);
    chk($sformatf("%s_tlasts%0d", t, k), st_last[k], ls);
    chk($sformatf("%s_donecount%0d", t, k), st_pkt[k], pk);
    if (bz >= 0) chk($sformatf("%s_busycycles%0d", t, k), st_busy[k], bz);
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; abort = 1'b0; num = '0; m_tready = 1'b1;
    s_tdata[0] = 32'h0; s_tdata[1] = 32'h1000_0000;
    s_tvalid[0] = 1'b1; s_tvalid[1] = 1'b1;
    repeat (3) step();
    rstn = 1'b1;
    step();
    chk("reset_busy", busy[0] || busy[1], 0);
    chk("reset_gen", gen_en[0] || gen_en[1], 0);
    chk("reset_tvalid", m_tvalid[0] || m_tvalid[1], 0);
    chk("reset_pkt", pkt_count[0], 0);

    // 3 packets, full throughput.
    pulse_start(3);
    wait_idle();
    totals("t1", 0, 12, 3, 3, 16);
    totals("t1", 1, 12, 3, 3, 12);

    // Same with consumer ready toggling every cycle.
    ready_mode = 1;
    pulse_start(3);
    wait_idle();
    totals("t2", 0, 12, 3, 3, -1);
    totals("t2", 1, 12, 3, 3, -1);

    // Continuous run, abort on beat 1 of packet 5 of the gapped instance.
    ready_mode = 0; m_tready = 1'b1;
    step();
    pulse_start(0);
    wait_xfer(0, 17);
    pulse_abort();
    wait_idle();
    totals("t3", 0, 20, 5, 5, -1);
    totals("t3", 1, 28, 7, 7, -1);

    // Abort on the first gap cycle after packet 1.
    pulse_start(0);
    wait_last(0, 1);
    pulse_abort();
    wait_idle();
    totals("t4", 0, 4, 1, 1, 5);
    totals("t4", 1, 8, 2, 2, 8);

    // Two packets; a start with a different count mid-run is ignored.
    pulse_start(2);
    repeat (3) step();
    pulse_start(7);
    wait_idle();
    totals("t5", 0, 8, 2, 2, 10);
    totals("t5", 1, 8, 2, 2, 8);

    // Reset mid-packet, then a clean single-packet run.
    num = '0;
    pulse_start(0);
    wait_xfer(0, 2);
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    chk("t6_busy", busy[0] || busy[1], 0);
    chk("t6_tvalid_tlast", m_tvalid[0] || m_tlast[0] || m_tvalid[1] || m_tlast[1], 0);
    chk("t6_pkt", pkt_count[0] | pkt_count[1], 0);
    step();
    pulse_start(1);
    wait_idle();
    totals("t6", 0, 4, 1, 1, 4);
    totals("t6", 1, 4, 1, 1, 4);

    // Random traffic, random aborts/starts, checked by the per-cycle model.
    src_mode = 1; ready_mode = 2;
    for (int r = 0; r < 30; r++) begin
      int n;
      pulse_start($urandom_range(0, 3));
      n = 0;
      while ((busy[0] || busy[1]) && n < 400) begin
        abort = (n > 60) || ($urandom_range(0, 19) == 0);
        start = (n < 60) && ($urandom_range(0, 9) == 0);
        num = NW'($urandom_range(0, 3));
        step();
        n++;
      end
      abort = 1'b0; start = 1'b0;
      chk("rand_run_timeout", busy[0] || busy[1], 0);
      repeat (2) step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
